// File: rtl/ex_muldiv_if.sv
// Operand/control bundle between the EX stage and the multiply/divide unit.
// The master drives the request and move signals; the slave returns HI/LO and status.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            mthi;
    logic            mtlo;
    logic            flush;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;
    logic            busy;
    logic            done;

    modport master (
        output start, op, SrcA, SrcB, mthi, mtlo, flush,
        input  HI, LO, busy, done
    );

    modport slave (
        input  start, op, SrcA, SrcB, mthi, mtlo, flush,
        output HI, LO, busy, done
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the single FIX cycle.
module ex_muldiv_unit #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] DIV0_LO = {XLEN{1'b1}}
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave bus
);
    localparam int            CW        = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            stateReg, stateNext;
    logic [CW-1:0]     counterReg;
    logic [2*XLEN-1:0] accReg;
    logic [XLEN-1:0]   operandReg;
    logic [XLEN-1:0]   hiReg, loReg;
    logic              isDivReg, div0Reg, negResReg, negRemReg, doneReg;

    // Issue decode on the live forwarded operands
    logic            issue, opSigned, divOp, negA, negB, divByZero;
    logic [XLEN-1:0] magA, magB;

    always_comb begin
        issue     = (stateReg == IDLE) && bus.start && !bus.flush;
        opSigned  = ~bus.op[0];
        divOp     = bus.op[1];
        negA      = opSigned & bus.SrcA[XLEN-1];
        negB      = opSigned & bus.SrcB[XLEN-1];
        magA      = negA ? -bus.SrcA : bus.SrcA;
        magB      = negB ? -bus.SrcB : bus.SrcB;
        divByZero = divOp && (bus.SrcB == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (issue) stateNext = divByZero ? FIX : CALC;
            CALC: begin
                if (bus.flush)                      stateNext = IDLE;
                else if (counterReg == LAST_ITER)   stateNext = FIX;
            end
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // One iteration. Multiply keeps {partial product, remaining multiplier bits};
    // divide keeps {remainder, remaining dividend bits / quotient bits}.
    logic [XLEN:0]     mulSum, divPartial, divDiff;
    logic [2*XLEN-1:0] stepNext;

    always_comb begin
        mulSum     = {1'b0, accReg[2*XLEN-1:XLEN]} + (accReg[0] ? {1'b0, operandReg} : '0);
        divPartial = accReg[2*XLEN-1:XLEN-1];
        divDiff    = divPartial - {1'b0, operandReg};
        if (!isDivReg)
            stepNext = {mulSum, accReg[XLEN-1:1]};
        else if (!divDiff[XLEN])
            stepNext = {divDiff[XLEN-1:0], accReg[XLEN-2:0], 1'b1};
        else
            stepNext = {divPartial[XLEN-1:0], accReg[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder, hiFinal, loFinal;

    always_comb begin
        product   = negResReg ? -accReg : accReg;
        quotient  = negResReg ? -accReg[XLEN-1:0] : accReg[XLEN-1:0];
        remainder = negRemReg ? -accReg[2*XLEN-1:XLEN] : accReg[2*XLEN-1:XLEN];
        if (div0Reg) begin
            // Raw dividend was parked in the low half at issue
            hiFinal = accReg[XLEN-1:0];
            loFinal = DIV0_LO;
        end else if (isDivReg) begin
            hiFinal = remainder;
            loFinal = quotient;
        end else begin
            hiFinal = product[2*XLEN-1:XLEN];
            loFinal = product[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counterReg <= '0;
            accReg     <= '0;
            operandReg <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            isDivReg   <= 1'b0;
            div0Reg    <= 1'b0;
            negResReg  <= 1'b0;
            negRemReg  <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (issue) begin
                        counterReg <= '0;
                        isDivReg   <= divOp;
                        div0Reg    <= divByZero;
                        negResReg  <= negA ^ negB;
                        negRemReg  <= negA;
                        if (divOp) begin
                            accReg     <= {{XLEN{1'b0}}, divByZero ? bus.SrcA : magA};
                            operandReg <= magB;
                        end else begin
                            accReg     <= {{XLEN{1'b0}}, magB};
                            operandReg <= magA;
                        end
                    end else if (!bus.start) begin
                        if (bus.mthi) hiReg <= bus.SrcA;
                        if (bus.mtlo) loReg <= bus.SrcA;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        accReg     <= stepNext;
                        counterReg <= counterReg + CW'(1);
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hiReg   <= hiFinal;
                        loReg   <= loFinal;
                        doneReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI   = hiReg;
    assign bus.LO   = loReg;
    assign bus.busy = (stateReg != IDLE);
    assign bus.done = doneReg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   nTests = 0;
    int   nFail  = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv_unit #(
        .XLEN   (XLEN),
        .DIV0_LO(32'hFFFFFFFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference: what HI/LO must hold after the instruction retires
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFFFFFF;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFFFFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Issues one op and collects observations; callers do their own comparisons
    task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc, output logic earlyDone, output logic doneSeen,
                            output logic [31:0] hi, output logic [31:0] lo, output logic doneLater);
        bus.op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
        cyc       = 0;
        earlyDone = 1'b0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (bus.done === 1'b1) earlyDone = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        doneSeen = bus.done;
        hi       = bus.HI;
        lo       = bus.LO;
        @(posedge clk); #1;
        doneLater = bus.done;
        $display("[TB] op=%0d a=%h b=%h busyCycles=%0d HI=%h LO=%h", op, a, b, cyc, hi, lo);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nTests++; if (bus.HI !== 32'h0)  begin nFail++; $display("FAIL reset_hi got=%h exp=0", bus.HI); end
        nTests++; if (bus.LO !== 32'h0)  begin nFail++; $display("FAIL reset_lo got=%h exp=0", bus.LO); end
        nTests++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        nTests++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        nTests++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_directed();
        logic [1:0]  tOp [5];
        logic [31:0] tA  [5];
        logic [31:0] tB  [5];
        logic [31:0] eh, el, hi, lo;
        logic        early, seen, later;
        int          cyc, expCyc;
        tOp = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
        tA  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        tB  = '{32'h00000002, 32'h00000007, 32'h00000002, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            refModel(tOp[i], tA[i], tB[i], eh, el);
            expCyc = (tOp[i][1] && tB[i] == 0) ? 1 : 33;
            issue_op(tOp[i], tA[i], tB[i], cyc, early, seen, hi, lo, later);
            nTests++; if (cyc !== expCyc) begin nFail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, cyc, expCyc); end
            nTests++; if (early !== 1'b0) begin nFail++; $display("FAIL dir%0d_early_done got=%b exp=0", i, early); end
            nTests++; if (seen !== 1'b1)  begin nFail++; $display("FAIL dir%0d_done got=%b exp=1", i, seen); end
            nTests++; if (hi !== eh)      begin nFail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, eh); end
            nTests++; if (lo !== el)      begin nFail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, el); end
            nTests++; if (later !== 1'b0) begin nFail++; $display("FAIL dir%0d_done_width got=%b exp=0", i, later); end
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        bus.op    = 2'd2;
        bus.SrcA  = 32'h80000000;
        bus.SrcB  = 32'hFFFFFFFF;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 2'd1; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
                bus.mthi  = 1'b1; bus.mtlo = 1'b1;
            end else if (cyc == 6) begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        $display("[TB] busy_start DIV 80000000/ffffffff busyCycles=%0d HI=%h LO=%h", cyc, bus.HI, bus.LO);
        nTests++; if (cyc !== 33)               begin nFail++; $display("FAIL busy_start_cycles got=%0d exp=33", cyc); end
        nTests++; if (bus.done !== 1'b1)        begin nFail++; $display("FAIL busy_start_done got=%b exp=1", bus.done); end
        nTests++; if (bus.LO !== 32'h80000000)  begin nFail++; $display("FAIL busy_start_lo got=%h exp=80000000", bus.LO); end
        nTests++; if (bus.HI !== 32'h0)         begin nFail++; $display("FAIL busy_start_hi got=%h exp=0", bus.HI); end
        @(posedge clk); #1;
        nTests++; if (bus.busy !== 1'b0)        begin nFail++; $display("FAIL busy_start_requeued got=%b exp=0", bus.busy); end
    endtask

    task automatic test_flush_move();
        logic [31:0] hi, lo;
        logic        early, seen, later;
        int          cyc, doneCount;
        issue_op(2'd1, 32'hFFFFFFFF, 32'h2, cyc, early, seen, hi, lo, later);
        nTests++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin nFail++; $display("FAIL flush_setup got=%h_%h exp=00000001_fffffffe", hi, lo); end
        bus.op = 2'd3; bus.SrcA = 32'd50; bus.SrcB = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 10 && bus.busy === 1'b1) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        $display("[TB] flush DIVU 50/7 at cycle %0d busy=%b done=%b", cyc, bus.busy, bus.done);
        nTests++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        nTests++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL flush_done got=%b exp=0", bus.done); end
        doneCount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) doneCount++;
        end
        nTests++; if (doneCount !== 0)        begin nFail++; $display("FAIL flush_late_done got=%0d exp=0", doneCount); end
        nTests++; if (bus.HI !== 32'h1)       begin nFail++; $display("FAIL flush_hi_kept got=%h exp=00000001", bus.HI); end
        nTests++; if (bus.LO !== 32'hFFFFFFFE) begin nFail++; $display("FAIL flush_lo_kept got=%h exp=fffffffe", bus.LO); end
        bus.mthi = 1'b1; bus.SrcA = 32'h1234;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        $display("[TB] mthi 00001234 HI=%h LO=%h", bus.HI, bus.LO);
        nTests++; if (bus.HI !== 32'h1234)     begin nFail++; $display("FAIL mthi_hi got=%h exp=00001234", bus.HI); end
        nTests++; if (bus.LO !== 32'hFFFFFFFE) begin nFail++; $display("FAIL mthi_lo got=%h exp=fffffffe", bus.LO); end
        nTests++; if (bus.done !== 1'b0)       begin nFail++; $display("FAIL mthi_done got=%b exp=0", bus.done); end
        bus.mtlo = 1'b1; bus.SrcA = 32'h5678;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        $display("[TB] mtlo 00005678 HI=%h LO=%h", bus.HI, bus.LO);
        nTests++; if (bus.LO !== 32'h5678) begin nFail++; $display("FAIL mtlo_lo got=%h exp=00005678", bus.LO); end
        nTests++; if (bus.HI !== 32'h1234) begin nFail++; $display("FAIL mtlo_hi got=%h exp=00001234", bus.HI); end
    endtask

    task automatic test_move_start();
        int cyc;
        bus.op = 2'd1; bus.SrcA = 32'd6; bus.SrcB = 32'd7;
        bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        nTests++; if (bus.HI !== 32'h1234) begin nFail++; $display("FAIL move_start_hi got=%h exp=00001234", bus.HI); end
        nTests++; if (bus.LO !== 32'h5678) begin nFail++; $display("FAIL move_start_lo got=%h exp=00005678", bus.LO); end
        nTests++; if (bus.busy !== 1'b1)   begin nFail++; $display("FAIL move_start_busy got=%b exp=1", bus.busy); end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("[TB] move+start MULTU 6*7 busyCycles=%0d HI=%h LO=%h", cyc, bus.HI, bus.LO);
        nTests++; if (bus.done !== 1'b1) begin nFail++; $display("FAIL move_start_done got=%b exp=1", bus.done); end
        nTests++; if (bus.LO !== 32'd42 || bus.HI !== 32'd0) begin nFail++; $display("FAIL move_start_result got=%h_%h exp=00000000_0000002a", bus.HI, bus.LO); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [31:0] hi, lo;
        logic        early, seen, later;
        int          cyc;
        bus.op = 2'd1; bus.SrcA = 32'h12345678; bus.SrcB = 32'h9ABCDEF0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-CALC HI=%h LO=%h busy=%b done=%b", bus.HI, bus.LO, bus.busy, bus.done);
        nTests++; if (bus.HI !== 32'h0)  begin nFail++; $display("FAIL areset_hi got=%h exp=0", bus.HI); end
        nTests++; if (bus.LO !== 32'h0)  begin nFail++; $display("FAIL areset_lo got=%h exp=0", bus.LO); end
        nTests++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
        nTests++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL areset_done got=%b exp=0", bus.done); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue_op(2'd1, 32'd6, 32'd7, cyc, early, seen, hi, lo, later);
        nTests++; if (cyc !== 33)  begin nFail++; $display("FAIL areset_mul_cycles got=%0d exp=33", cyc); end
        nTests++; if (lo !== 32'd42 || hi !== 32'd0) begin nFail++; $display("FAIL areset_mul got=%h_%h exp=00000000_0000002a", hi, lo); end
        nTests++; if (seen !== 1'b1) begin nFail++; $display("FAIL areset_mul_done got=%b exp=1", seen); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, eh, el, hi, lo;
        logic        early, seen, later;
        int          cyc, expCyc;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'h80000000;
                3:       b = 32'h1;
                4:       b = 32'($urandom_range(2, 255));
                default: b = $urandom;
            endcase
            refModel(op, a, b, eh, el);
            expCyc = (op[1] && b == 0) ? 1 : 33;
            issue_op(op, a, b, cyc, early, seen, hi, lo, later);
            nTests++; if (cyc !== expCyc) begin nFail++; $display("FAIL rnd%0d_busy_cycles got=%0d exp=%0d", i, cyc, expCyc); end
            nTests++; if (seen !== 1'b1 || early !== 1'b0 || later !== 1'b0) begin nFail++; $display("FAIL rnd%0d_done_pulse got=%b%b%b exp=010", i, early, seen, later); end
            nTests++; if (hi !== eh) begin nFail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, hi, eh); end
            nTests++; if (lo !== el) begin nFail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, lo, el); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.flush = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_directed();
        test_busy_start();
        test_flush_move();
        test_move_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
